// File: rtl/rgb_to_ycc_ci_if.sv
// Custom-instruction bus between the Nios II core (master) and the RGB->YCbCr unit (slave).
// Handshake: start is a one-cycle request honoured only when the unit is idle and clk_en=1;
// done is a one-enabled-cycle pulse marking result valid, and result holds until the next completion.
interface rgb_to_ycc_ci_if;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    modport master (
        output clk_en, start, n, data_a, data_b,
        input  done, result, dbg_state
    );

    modport slave (
        input  clk_en, start, n, data_a, data_b,
        output done, result, dbg_state
    );
endinterface

// File: rtl/rgb_to_ycc_ci.sv
// Multi-cycle RGB888 -> JFIF YCbCr conversion with one shared signed MAC.
// Walks R, G, B coefficient terms per component; n=3 runs Y, Cb, Cr back to back and packs them.
module rgb_to_ycc_ci #(
    parameter int FRAC_BITS = 16,
    parameter bit ROUND     = 1'b1
) (
    input logic            clk,
    input logic            reset,
    rgb_to_ycc_ci_if.slave ci
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         comp_q, comp_d;
    logic [1:0]         term_q, term_d;
    logic [1:0]         n_q, n_d;
    logic signed [26:0] acc_q, acc_d;
    logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]         y_q, y_d, cb_q, cb_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;

    logic [7:0]         chan;
    logic signed [16:0] coef_sel;
    logic signed [25:0] prod;
    logic signed [26:0] shifted;
    logic [7:0]         sat_val;
    logic [1:0]         first_comp;
    logic               unused_bits;

    assign unused_bits = ^{ci.data_b, ci.data_a[31:24]};

    function automatic logic signed [16:0] coef(input logic [1:0] c, input logic [1:0] t);
        logic signed [16:0] k;
        k = 17'sd0;
        case ({c, t})
            4'b00_00: k = 17'sd19595;
            4'b00_01: k = 17'sd38470;
            4'b00_10: k = 17'sd7471;
            4'b01_00: k = -17'sd11056;
            4'b01_01: k = -17'sd21712;
            4'b01_10: k = 17'sd32768;
            4'b10_00: k = 17'sd32768;
            4'b10_01: k = -17'sd27440;
            4'b10_10: k = -17'sd5328;
            default:  k = 17'sd0;
        endcase
        return k;
    endfunction

    // Chroma carries a +128 offset; the rounding half-LSB is folded into the same preload.
    function automatic logic signed [26:0] preload(input logic [1:0] c);
        logic signed [26:0] p;
        p = (c == 2'd0) ? 27'sd0 : (27'sd128 <<< FRAC_BITS);
        if (ROUND)
            p = p + (27'sd1 <<< (FRAC_BITS - 1));
        return p;
    endfunction

    always_comb begin
        state_d  = state_q;
        comp_d   = comp_q;
        term_d   = term_q;
        n_d      = n_q;
        acc_d    = acc_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        y_d      = y_q;
        cb_d     = cb_q;
        done_d   = done_q;
        result_d = result_q;

        chan       = (term_q == 2'd0) ? r_q : (term_q == 2'd1) ? g_q : b_q;
        coef_sel   = coef(comp_q, term_q);
        prod       = coef_sel * $signed({1'b0, chan});
        shifted    = acc_q >>> FRAC_BITS;
        first_comp = (ci.n == 2'd3) ? 2'd0 : ci.n;

        if (shifted < 27'sd0)
            sat_val = 8'd0;
        else if (shifted > 27'sd255)
            sat_val = 8'd255;
        else
            sat_val = shifted[7:0];

        if (ci.clk_en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (ci.start) begin
                        r_d     = ci.data_a[23:16];
                        g_d     = ci.data_a[15:8];
                        b_d     = ci.data_a[7:0];
                        n_d     = ci.n;
                        comp_d  = first_comp;
                        acc_d   = preload(first_comp);
                        term_d  = 2'd0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    acc_d  = acc_q + {prod[25], prod};
                    term_d = term_q + 2'd1;
                    if (term_q == 2'd2)
                        state_d = SAT;
                end
                SAT: begin
                    if (n_q != 2'd3) begin
                        result_d = {24'h0, sat_val};
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (comp_q == 2'd2) begin
                        result_d = {8'h00, y_q, cb_q, sat_val};
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        if (comp_q == 2'd0)
                            y_d = sat_val;
                        else
                            cb_d = sat_val;
                        comp_d  = comp_q + 2'd1;
                        acc_d   = preload(comp_q + 2'd1);
                        term_d  = 2'd0;
                        state_d = ACC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            comp_q   <= 2'd0;
            term_q   <= 2'd0;
            n_q      <= 2'd0;
            acc_q    <= 27'sd0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
            y_q      <= 8'd0;
            cb_q     <= 8'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            comp_q   <= comp_d;
            term_q   <= term_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            y_q      <= y_d;
            cb_q     <= cb_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign ci.done      = done_q;
    assign ci.result    = result_q;
    assign ci.dbg_state = state_q;

endmodule

// File: tb/tb_rgb_to_ycc_ci.sv
// Directed and randomized checks of rgb_to_ycc_ci against an arithmetic colour-space model.
module tb_rgb_to_ycc_ci;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    rgb_to_ycc_ci_if ci ();

    rgb_to_ycc_ci #(.FRAC_BITS(16), .ROUND(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .ci    (ci.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JFIF equations in integer fixed point, round half up, clamp to a byte.
    function automatic logic [7:0] ref_comp(input int r, input int g, input int b, input int c);
        int sum;
        int v;
        case (c)
            0:       sum = 19595 * r + 38470 * g + 7471 * b;
            1:       sum = -11056 * r - 21712 * g + 32768 * b + 128 * 65536;
            default: sum = 32768 * r - 27440 * g - 5328 * b + 128 * 65536;
        endcase
        v = (sum + 32768) >>> 16;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v[7:0];
    endfunction

    function automatic logic [31:0] ref_pixel(input logic [31:0] a, input logic [1:0] nn);
        int r, g, b;
        r = int'(a[23:16]);
        g = int'(a[15:8]);
        b = int'(a[7:0]);
        if (nn == 2'd3)
            return {8'h00, ref_comp(r, g, b, 0), ref_comp(r, g, b, 1), ref_comp(r, g, b, 2)};
        return {24'h0, ref_comp(r, g, b, int'(nn))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and counts edges until done; clk_en drops for stall_len edges after edge stall_at.
    task automatic run_op(input logic [31:0] a, input logic [1:0] nn, input int stall_at,
                          input int stall_len, output logic [31:0] res, output int lat);
        ci.clk_en = 1'b1;
        ci.start  = 1'b1;
        ci.data_a = a;
        ci.n      = nn;
        ci.data_b = $urandom;
        @(posedge clk); #1;
        ci.start  = 1'b0;
        ci.data_a = $urandom;
        ci.n      = 2'($urandom_range(0, 3));
        lat = -1;
        res = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ci.done === 1'b1) begin
                lat = k;
                res = ci.result;
                break;
            end
            if (k == stall_at) ci.clk_en = 1'b0;
            if (k == stall_at + stall_len) ci.clk_en = 1'b1;
        end
        ci.clk_en = 1'b1;
    endtask

    logic [31:0] res;
    int          lat;
    logic [31:0] a;
    logic [1:0]  nn;
    int          slen;
    int          dones;
    logic [31:0] held;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        ci.clk_en = 1'b1;
        ci.start  = 1'b0;
        ci.n      = 2'd0;
        ci.data_a = 32'h0;
        ci.data_b = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_done", {31'h0, ci.done}, 32'h0);
        check("reset_result", ci.result, 32'h0);
        check("reset_state_idle", {30'h0, ci.dbg_state}, 32'h0);

        // All-zero pixel, packed
        run_op(32'h0000_0000, 2'd3, 0, 0, res, lat);
        check("zero_packed", res, 32'h0000_8080);
        check("zero_packed_lat", lat, 12);

        // Red, every selector
        run_op(32'h00FF_0000, 2'd0, 0, 0, res, lat);
        check("red_y", res, 32'h0000_004C);
        check("red_y_lat", lat, 4);
        run_op(32'h00FF_0000, 2'd1, 0, 0, res, lat);
        check("red_cb", res, 32'h0000_0055);
        check("red_cb_lat", lat, 4);
        run_op(32'h00FF_0000, 2'd2, 0, 0, res, lat);
        check("red_cr_clamp", res, 32'h0000_00FF);
        check("red_cr_lat", lat, 4);
        run_op(32'h00FF_0000, 2'd3, 0, 0, res, lat);
        check("red_packed", res, 32'h004C_55FF);

        run_op(32'h0000_00FF, 2'd3, 0, 0, res, lat);
        check("blue_packed", res, 32'h001D_FF6B);
        run_op(32'hAAFF_FFFF, 2'd3, 0, 0, res, lat);
        check("white_packed", res, 32'h00FF_8080);

        // Back-to-back: second start issued while done is high
        run_op(32'h00FF_0000, 2'd0, 0, 0, res, lat);
        check("b2b_first", res, 32'h0000_004C);
        check("b2b_done_high", {31'h0, ci.done}, 32'h1);
        run_op(32'h0000_00FF, 2'd2, 0, 0, res, lat);
        check("b2b_second", res, 32'h0000_006B);
        check("b2b_second_lat", lat, 4);

        // Start during ACC is ignored and must not queue
        ci.start = 1'b1; ci.data_a = 32'h00FF_0000; ci.n = 2'd1;
        @(posedge clk); #1;
        ci.start = 1'b0;
        @(posedge clk); #1;
        ci.start = 1'b1; ci.data_a = 32'h0000_00FF; ci.n = 2'd0;
        @(posedge clk); #1;
        ci.start = 1'b0;
        dones = 0;
        held  = 32'h0;
        for (int k = 0; k < 16; k++) begin
            if (ci.done === 1'b1) begin
                dones++;
                held = ci.result;
            end
            @(posedge clk); #1;
        end
        check("acc_start_one_done", dones, 1);
        check("acc_start_result", held, 32'h0000_0055);

        // clk_en stall of 3 edges mid-ACC
        run_op(32'h00FF_0000, 2'd1, 1, 3, res, lat);
        check("stall_result", res, 32'h0000_0055);
        check("stall_lat", lat, 7);
        ci.clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", {31'h0, ci.done}, 32'h1);
        check("hold_result", ci.result, 32'h0000_0055);
        ci.clk_en = 1'b1;
        @(posedge clk); #1;
        check("done_clears", {31'h0, ci.done}, 32'h0);
        check("result_persists", ci.result, 32'h0000_0055);

        // Reset during the final SAT of a packed operation
        ci.start = 1'b1; ci.data_a = 32'h00FF_0000; ci.n = 2'd3;
        @(posedge clk); #1;
        ci.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_done", {31'h0, ci.done}, 32'h0);
        check("abort_result", ci.result, 32'h0);
        check("abort_state_idle", {30'h0, ci.dbg_state}, 32'h0);
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (ci.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(32'h00FF_FFFF, 2'd0, 0, 0, res, lat);
        check("post_abort_white_y", res, 32'h0000_00FF);
        check("post_abort_lat", lat, 4);

        // Random pixels and selectors, with occasional clk_en stalls
        for (int i = 0; i < 24; i++) begin
            a    = $urandom;
            nn   = 2'($urandom_range(0, 3));
            slen = $urandom_range(0, 2);
            run_op(a, nn, $urandom_range(1, 3), slen, res, lat);
            check("rand_result", res, ref_pixel(a, nn));
            check("rand_lat", lat, ((nn == 2'd3) ? 12 : 4) + slen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
